// File: rtl/risc_lsu_32.sv
// Load/store unit: turns byte-addressed RV32 loads/stores into word accesses on a
// word-indexed data memory, doing read-modify-write for SB/SH and extending loads.
module risc_lsu_32 #(
  parameter int MEM_DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'd4 << MEM_DEPTH_LOG2;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  // Request classification works on the live request so the error path needs no extra state.
  logic f3_legal, store_bad, misaligned, out_of_range, req_err;

  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    store_bad    = req_write & req_funct3[2];
    out_of_range = (req_addr >= ADDR_LIMIT);
    req_err      = ~f3_legal | store_bad | misaligned | out_of_range;
  end

  logic [7:0]  rd_lane [4];
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] merged_word;

  always_comb begin
    if (funct3_q[0]) begin
      byte_en    = addr_q[1] ? 4'b1100 : 4'b0011;
      store_word = {2{wdata_q[15:0]}};
    end else begin
      byte_en    = 4'b0001 << addr_q[1:0];
      store_word = {4{wdata_q[7:0]}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = mem_rdata[8*gi +: 8];
      assign merged_word[8*gi +: 8] = byte_en[gi] ? store_word[8*gi +: 8]
                                                  : merge_q[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    byte_sel = rd_lane[addr_q[1:0]];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Memory-port outputs are decoded from state so reset removes mem_we without waiting for a clock.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_addr    = 32'h0;
    mem_we      = 1'b0;
    mem_wdata   = 32'h0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_err) begin
            rsp_rdata_d = 32'h0;
            rsp_error_d = 1'b1;
            state_d     = RESP;
          end else if (!req_write) begin
            state_d = LOAD;
          end else if (req_funct3[1]) begin
            state_d = STORE_W;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_addr    = {2'b00, addr_q[31:2]};
        rsp_rdata_d = load_ext;
        rsp_error_d = 1'b0;
        state_d     = RESP;
      end
      STORE_W: begin
        mem_addr    = {2'b00, addr_q[31:2]};
        mem_we      = 1'b1;
        mem_wdata   = wdata_q;
        rsp_rdata_d = 32'h0;
        rsp_error_d = 1'b0;
        state_d     = RESP;
      end
      RMW_RD: begin
        mem_addr = {2'b00, addr_q[31:2]};
        merge_d  = mem_rdata;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        mem_addr    = {2'b00, addr_q[31:2]};
        mem_we      = 1'b1;
        mem_wdata   = merged_word;
        rsp_rdata_d = 32'h0;
        rsp_error_d = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merge_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  // write_q is kept for visibility of the accepted request; routing is already encoded in state.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_risc_lsu_32.sv
// Randomized and directed bench for risc_lsu_32 against a byte-level memory reference model.
module tb_risc_lsu_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  risc_lsu_32 #(.MEM_DEPTH_LOG2(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory environment plus a side port for preloading.
  logic [31:0] mem [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = 6'd0;
  logic [31:0] ld_data = 32'h0;

  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  logic [31:0] ref_mem [64];
  int total = 0;
  int bad = 0;
  int txn_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_word(input int idx, input logic [31:0] v);
    ld_en   = 1'b1;
    ld_addr = 6'(idx);
    ld_data = v;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Reference: RV32 byte-addressed semantics over an array of words.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic err, output logic [31:0] rdata,
                       output int lat, output int we_n);
    int size;
    logic [31:0] word, mask, raw, v, sh;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (w && f3 >= 3'd4)
          || (a % size != 0) || (a >= 32'd256);
    rdata = 32'h0;
    lat = 1;
    we_n = 0;
    if (err) return;
    word = ref_mem[a / 4];
    sh = (a % 4) * 8;
    if (!w) begin
      raw = word >> sh;
      if (size == 1) begin
        v = raw & 32'hFF;
        if (f3 < 3'd4 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = raw & 32'hFFFF;
        if (f3 < 3'd4 && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
      rdata = v;
      lat = 2;
    end else begin
      if (size == 4) mask = 32'hFFFF_FFFF;
      else mask = (32'd1 << (8 * size)) - 32'd1;
      mask = mask << sh;
      ref_mem[a / 4] = (word & ~mask) | ((d << sh) & mask);
      lat = (size == 4) ? 2 : 3;
      we_n = 1;
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, output int waits);
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
  endtask

  task automatic collect(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got);
    logic e_err;
    logic [31:0] e_rd;
    int e_lat, e_we, cycles, we_cnt, rdy_bad, wd_bad;
    model(w, f3, a, d, e_err, e_rd, e_lat, e_we);
    cycles = 0; we_cnt = 0; rdy_bad = 0; wd_bad = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (mem_we) we_cnt++;
      if (!mem_we && mem_wdata != 32'h0) wd_bad++;
      if (req_ready) rdy_bad++;
    end while (!rsp_valid && cycles < 10);
    got = rsp_rdata;
    txn_no++;
    $display("txn %0d w=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             txn_no, w, f3, a, d, rsp_rdata, rsp_error, cycles);
    chk("latency", 32'(cycles), 32'(e_lat));
    chk("rsp_error", {31'h0, rsp_error}, {31'h0, e_err});
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("we_cycles", 32'(we_cnt), 32'(e_we));
    chk("ready_busy", 32'(rdy_bad), 32'd0);
    chk("wdata_idle", 32'(wd_bad), 32'd0);
    if (a < 32'd256) chk("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);
  endtask

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] got);
    int waits;
    issue(w, f3, a, d, 1'b0, waits);
    collect(w, f3, a, d, got);
  endtask

  initial begin
    logic [31:0] got;
    int waits;
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    for (int i = 0; i < 64; i++) load_word(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_error", {31'h0, rsp_error}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);

    // Directed loads from word 3
    load_word(3, 32'h8081_F2F3);
    txn(1'b0, 3'b000, 32'h0D, 32'h0, got); chk("tp_lb", got, 32'hFFFF_FFF2);
    txn(1'b0, 3'b100, 32'h0D, 32'h0, got); chk("tp_lbu", got, 32'h0000_00F2);
    txn(1'b0, 3'b001, 32'h0E, 32'h0, got); chk("tp_lh", got, 32'hFFFF_8081);
    txn(1'b0, 3'b101, 32'h0C, 32'h0, got); chk("tp_lhu", got, 32'h0000_F2F3);
    txn(1'b0, 3'b010, 32'h0C, 32'h0, got); chk("tp_lw", got, 32'h8081_F2F3);

    // Directed sub-word stores to word 5
    load_word(5, 32'h1122_3344);
    txn(1'b1, 3'b000, 32'h17, 32'hAABB_CCDD, got); chk("tp_sb", mem[5], 32'hDD22_3344);
    txn(1'b1, 3'b001, 32'h14, 32'h0000_BEEF, got); chk("tp_sh", mem[5], 32'hDD22_BEEF);

    // Directed error requests
    txn(1'b1, 3'b010, 32'h02, 32'h1234_5678, got); chk("tp_sw_mis", got, 32'h0);
    txn(1'b0, 3'b001, 32'h01, 32'h0, got);         chk("tp_lh_mis", got, 32'h0);
    txn(1'b0, 3'b000, 32'h100, 32'h0, got);        chk("tp_lb_oor", got, 32'h0);
    txn(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, got); chk("tp_sbu_bad", got, 32'h0);

    // Request held valid across a busy period
    issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b1, waits);
    req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h15; req_wdata = 32'h0000_0077;
    collect(1'b0, 3'b010, 32'h0C, 32'h0, got);
    issue(1'b1, 3'b000, 32'h15, 32'h0000_0077, 1'b0, waits);
    chk("held_accept_wait", 32'(waits), 32'd1);
    collect(1'b1, 3'b000, 32'h15, 32'h0000_0077, got);
    chk("held_word", mem[5], 32'hDD22_77EF);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic w;
      logic [2:0] f3;
      logic [31:0] a;
      int k;
      w  = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)]
                                       : 3'($urandom_range(0, 7));
      k = int'($urandom_range(0, 9));
      if (k < 8) begin
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) begin
          if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
          else if (f3[1:0] == 2'd1) a[0] = 1'b0;
        end
      end else if (k == 8) begin
        a = 32'd256 + 32'($urandom_range(0, 300));
      end else begin
        a = $urandom;
      end
      txn(w, f3, a, $urandom, got);
    end

    // Reset during RMW_WR of an SB to word 7
    load_word(7, 32'h0);
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1C; req_wdata = 32'h0000_00FF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_wr_we", {31'h0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'h0, mem_we}, 32'd0);
    chk("arst_valid", {31'h0, rsp_valid}, 32'd0);
    chk("arst_rdata", rsp_rdata, 32'h0);
    chk("arst_error", {31'h0, rsp_error}, 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", {31'h0, req_ready}, 32'd1);
    chk("arst_word7", mem[7], 32'h0);

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_lsu_32.md
Name: risc_lsu_32

Overview:
- Load/store unit for the 32-bit RISC-V core. Sits between the execute stage and the 64-entry word-addressed data memory.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the memory port.
- Performs sub-word stores as read-modify-write, and sign/zero-extends loads.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- MEM_DEPTH_LOG2, 6, log2 of data-memory word count; legal byte addresses are 0 .. (4<<MEM_DEPTH_LOG2)-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (low byte/half used for SB/SH).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  access rejected; valid with rsp_valid.
- mem_addr  output  32  word index to data memory.
- mem_we  output  1  data-memory write enable.
- mem_wdata  output  32  data-memory write word.
- mem_rdata  input  32  data-memory asynchronous read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE; latched request and merge registers cleared; rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=1 once reset deasserts.
- Reset mid-operation aborts immediately. mem_we is decoded from state, so it drops asynchronously and no partial write occurs after reset assertion.
- States: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata, then classify the request.
- Classification (any of these makes an error request, which goes to RESP with rsp_error=1 and no mem_we):
  - funct3 not in {000,001,010,100,101}.
  - Store with funct3 100/101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr >= 4<<MEM_DEPTH_LOG2.
- Non-error transitions from IDLE:
  - Load -> LOAD.
  - SW -> STORE_W.
  - SB/SH -> RMW_RD.
- Memory port drive:
  - req_ready=0 in every state except IDLE; req_valid is ignored while busy.
  - mem_addr = latched addr >> 2 in LOAD, STORE_W, RMW_RD and RMW_WR; 0 otherwise.
  - mem_we=1 only in STORE_W and RMW_WR.
  - mem_wdata = 0 whenever mem_we=0.
- LOAD:
  - Capture mem_rdata.
  - Select byte addr[1:0] or half addr[1], with lane 0 = bits [7:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Store the result in the rsp_rdata register, then go to RESP.
- STORE_W: mem_wdata = wdata, then go to RESP.
- RMW_RD: capture mem_rdata into the merge register, then go to RMW_WR. mem_we=0 here, so the memory read port is valid.
- RMW_WR: mem_wdata = merge register with the addressed byte (SB, wdata[7:0]) or half (SH, wdata[15:0]) replaced; all other bits unchanged. Then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. rsp_rdata and rsp_error hold until the next response.
- Latency from the accept edge to rsp_valid:
  - Error: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: a new request is accepted only in IDLE, so back-to-back requests each pay the full latency plus the accept cycle.

Test Plan:
- Preload mem word 3 = 0x8081_F2F3; LB addr 0x0D -> rsp_rdata 0xFFFF_FFF2, rsp_error 0, rsp_valid exactly 2 cycles after accept. LBU same address -> 0x0000_00F2.
- Same preload; LH addr 0x0E -> 0xFFFF_8081; LHU addr 0x0C -> 0x0000_F2F3; LW addr 0x0C -> 0x8081_F2F3.
- Preload word 5 = 0x1122_3344; SB addr 0x17 wdata 0xAABB_CCDD -> word 5 = 0xDD22_3344. Then SH addr 0x14 wdata 0x0000_BEEF -> word 5 = 0xDD22_BEEF. mem_we high exactly one cycle per store; rsp_valid 3 cycles after accept.
- SW addr 0x02, LH addr 0x01, LB addr 0x100, SB funct3 100 -> each rsp_error=1 and rsp_rdata=0 one cycle after accept; mem_we never asserted; memory contents unchanged.
- Hold req_valid high across a busy period with a different request -> req_ready=0 while busy; second request accepted only on the first IDLE cycle and completes correctly.
- Assert rst_n=0 during RMW_WR of SB to word 7 (preloaded 0x0) -> mem_we drops immediately; word 7 remains 0x0; all outputs zero; req_ready=1 after release.
